// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: instruction delivery handshake between fetch stage and CPU.
//   instr_valid  head of the fetch queue holds an instruction
//   instr_ready  CPU consumes the head this cycle
//   instr        instruction word at the head
//   instr_pc     address the head instruction was fetched from
// master = fetch stage, slave = CPU.
interface fetch_buffer_if #(
    parameter int AW = 15,
    parameter int DW = 16
);
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
    modport slave (input instr_valid, input instr, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch stage that reads the instruction ROM and queues {pc, instr} for the CPU.
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   rom_addr     ROM address, always equal to the fetch address
//   rom_data     combinational ROM word at rom_addr
//   bus          fetch_buffer_if.master: instr_valid/instr_ready/instr/instr_pc
//   jump         single-cycle redirect; flushes the queue, fetch restarts at jump_target
//   jump_target  redirect address
//   halt         stop fetching; queued entries still drain
//   fetch_count  pushes so far, saturating (FETCH_STATS_EN only, else 0)
//   flush_count  entries discarded by jumps, saturating (FETCH_STATS_EN only, else 0)
// Optional feature macro: FETCH_STATS_EN.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 15,
    parameter int          DW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    fetch_buffer_if.master bus,
    input  logic          jump,
    input  logic [AW-1:0] jump_target,
    input  logic          halt,
    output logic [15:0]   fetch_count,
    output logic [15:0]   flush_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [PW:0]      count;
    logic [AW-1:0]    fetch_pc;
    logic             push, pop;

    assign rom_addr        = fetch_pc;
    assign bus.instr_valid = count != '0;
    assign pop             = bus.instr_valid && bus.instr_ready;
    // a full queue may still accept when the head leaves on the same edge
    assign push            = !jump && !halt && (count != FULL || pop);
    assign {bus.instr_pc, bus.instr} = bus.instr_valid ? mem[head] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= AW'(RESET_PC);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (jump) begin
            // redirect wins: any handshake on this edge is discarded with the queue
            fetch_pc <= jump_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + AW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock)
        if (push)
            mem[tail] <= {fetch_pc, rom_data};

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt, flush_cnt;
    logic [16:0] flush_sum;

    assign flush_sum   = {1'b0, flush_cnt} + 17'(count);
    assign fetch_count = fetch_cnt;
    assign flush_count = flush_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (jump)
                flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized check of fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clock = 0;
    logic        reset_n = 0;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        jump = 0;
    logic [14:0] jump_target = '0;
    logic        halt = 0;
    logic [15:0] fetch_count, flush_count;

    fetch_buffer_if #(.AW(15), .DW(16)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .AW(15), .DW(16), .RESET_PC(0)) dut (
        .clock(clock), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .bus(bus), .jump(jump), .jump_target(jump_target), .halt(halt),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] rom(input logic [14:0] a);
        return {1'b0, a} + 16'h0100;
    endfunction

    assign rom_data = rom(rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference: queue of {pc, instr}, next fetch address, stat totals
    logic [30:0] q[$];
    logic [14:0] mpc;
    int          mfetch, mflush;
    logic [14:0] held;

    task automatic mreset();
        q.delete();
        mpc    = '0;
        mfetch = 0;
        mflush = 0;
    endtask

    task automatic model_step();
        int   n;
        logic taken;
        n     = q.size();
        taken = n > 0 && bus.instr_ready;
        if (jump) begin
            mflush = (mflush + n > 65535) ? 65535 : mflush + n;
            q.delete();
            mpc = jump_target;
        end else begin
            if (taken) void'(q.pop_front());
            if (!halt && (n < DEPTH || taken)) begin
                q.push_back({mpc, rom(mpc)});
                mpc++;
                if (mfetch < 65535) mfetch++;
            end
        end
    endtask

    task automatic compare();
        chk("valid", bus.instr_valid, q.size() != 0);
        chk("instr", bus.instr, q.size() != 0 ? 32'(q[0][15:0]) : 32'h0);
        chk("instr_pc", bus.instr_pc, q.size() != 0 ? 32'(q[0][30:16]) : 32'h0);
        chk("rom_addr", rom_addr, mpc);
`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, mfetch);
        chk("flush_count", flush_count, mflush);
`else
        chk("fetch_count", fetch_count, 0);
        chk("flush_count", flush_count, 0);
`endif
    endtask

    task automatic cyc(input logic r, input logic j, input logic [14:0] t, input logic h);
        bus.instr_ready = r;
        jump            = j;
        jump_target     = t;
        halt            = h;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    // reset asserted between edges, checked before the next edge, released at a negedge
    task automatic areset();
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        mreset();
        compare();
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        logic [14:0] wrap_pc [4];
        wrap_pc = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        bus.instr_ready = 0;
        mreset();
        #2 compare();
        @(negedge clock);
        compare();
        reset_n = 1;

        cyc(1, 0, 0, 0);
        chk("first_valid", bus.instr_valid, 1);
        chk("first_instr", bus.instr, 16'h0100);
        chk("first_pc", bus.instr_pc, 0);
        repeat (7) cyc(1, 0, 0, 0);

        areset();
        repeat (10) cyc(0, 0, 0, 0);
        chk("stall_addr", rom_addr, 4);
        chk("stall_instr", bus.instr, 16'h0100);
        repeat (8) cyc(1, 0, 0, 0);

        areset();
        cyc(1, 1, 15'h0010, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 1, 15'h0050, 0);
        chk("jump_valid", bus.instr_valid, 0);
        chk("jump_addr", rom_addr, 15'h0050);
        cyc(1, 0, 0, 0);
        chk("jump_pc", bus.instr_pc, 15'h0050);
`ifdef FETCH_STATS_EN
        chk("flush3", flush_count, 3);
`endif

        cyc(1, 1, 15'h7FFE, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            chk("wrap_pc", bus.instr_pc, wrap_pc[i]);
        end

        repeat (6) cyc(0, 0, 0, 0);
        held = rom_addr;
        repeat (4) cyc(1, 0, 0, 1);
        chk("drain_valid", bus.instr_valid, 0);
        cyc(1, 0, 0, 1);
        chk("halt_addr", rom_addr, held);
        cyc(1, 0, 0, 0);
        chk("resume_pc", bus.instr_pc, held);

        cyc(1, 1, 15'h0123, 1);
        cyc(1, 0, 0, 1);
        chk("jh_valid", bus.instr_valid, 0);
        chk("jh_addr", rom_addr, 15'h0123);
        cyc(1, 0, 0, 0);
        chk("jh_pc", bus.instr_pc, 15'h0123);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) areset();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                15'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
